mem_arbiter: RTL and testbench

- Arbitrates the single main-memory port between I-cache refills and D-cache refills/writebacks.
- Sits below both caches; its per-port ack drives cache completion, which ends iCacheStall and the D-side stall.
- Serialises one line transfer at a time through a small FSM.
- Registers all memory-side outputs.

---
 rtl/mem_arb_pkg.sv | 35 +++
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types, default widths and grant selection for the main-memory arbiter.
// Latency: none; this file holds declarations and one pure function.
// Backpressure: not applicable; pick_grant is evaluated only when a request is pending.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  // A lone requester always wins. On contention, round-robin hands the port to
  // whoever did not win last time; otherwise the D-cache wins.
  function automatic grant_t pick_grant(input logic ic_req, input logic dc_req,
                                        input grant_t last_grant, input logic rr);
    grant_t g;
    g = GNT_D;
    if (ic_req && dc_req) begin
      g = (rr && (last_grant == GNT_D)) ? GNT_I : GNT_D;
    end else if (ic_req) begin
      g = GNT_I;
    end
    return g;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the I-cache, D-cache and main-memory handshakes of the arbiter.
// Latency: none; wires only.
// Backpressure: requests are levels held until the matching one-cycle ack.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) ();

  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_ack;
  logic [LINE_W-1:0] ic_rdata;

  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [LINE_W-1:0] dc_wdata;
  logic              dc_ack;
  logic [LINE_W-1:0] dc_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_rdata;

  // Arbiter view: takes cache requests and memory completions, drives the rest.
  modport master (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ack, mem_rdata,
    output ic_ack, ic_rdata, dc_ack, dc_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  // Environment view: the two caches plus the memory controller.
  modport slave (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ack, mem_rdata,
    input  ic_ack, ic_rdata, dc_ack, dc_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Serialises I-cache refills and D-cache refills/writebacks onto one memory port (MEM_ARB_RR_EN selects round-robin).
// Latency: mem_req 1 cycle after req; port ack 1 cycle after mem_ack; back in IDLE the cycle after that.
// Backpressure: one line in flight; losers wait as held requests, memory stalls by delaying mem_ack.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus,
  output logic          busy
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_BUSY_I = BUSY_I;
  localparam logic [1:0] S_BUSY_D = BUSY_D;
  localparam logic [1:0] S_RESP   = RESP;

`ifdef MEM_ARB_RR_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif

  logic [1:0]        state;
  grant_t            last_grant;
  grant_t            gnt;
  logic              ic_ack_q;
  logic              dc_ack_q;
  logic [LINE_W-1:0] ic_rdata_q;
  logic [LINE_W-1:0] dc_rdata_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;

  // Candidate winner for the next IDLE grant.
  always_comb begin
    gnt = pick_grant(bus.ic_req, bus.dc_req, last_grant, RR);
  end

  // Transfer FSM; every output is a flop updated here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      last_grant  <= GNT_D;
      ic_ack_q    <= 1'b0;
      dc_ack_q    <= 1'b0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.ic_req || bus.dc_req) begin
            mem_req_q  <= 1'b1;
            last_grant <= gnt;
            if (gnt == GNT_D) begin
              state       <= S_BUSY_D;
              mem_we_q    <= bus.dc_we;
              mem_addr_q  <= bus.dc_addr;
              mem_wdata_q <= bus.dc_wdata;
            end else begin
              state       <= S_BUSY_I;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= bus.ic_addr;
              mem_wdata_q <= '0;
            end
          end
        end
        S_BUSY_I: begin
          if (bus.mem_ack) begin
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            ic_ack_q   <= 1'b1;
            ic_rdata_q <= bus.mem_rdata;
            state      <= S_RESP;
          end
        end
        S_BUSY_D: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            dc_ack_q  <= 1'b1;
            // Writebacks leave the last refill line visible to the D-cache.
            if (!mem_we_q) begin
              dc_rdata_q <= bus.mem_rdata;
            end
            state <= S_RESP;
          end
        end
        default: begin
          // One dead cycle lets the served cache drop its request before re-arbitration.
          ic_ack_q <= 1'b0;
          dc_ack_q <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ic_ack    = ic_ack_q;
  assign bus.ic_rdata  = ic_rdata_q;
  assign bus.dc_ack    = dc_ack_q;
  assign bus.dc_rdata  = dc_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, I refill, D writeback, reset mid-transfer, contention.
// Latency: inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Backpressure: memory completion is driven by hand through mem_ack.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk;
  logic rst;
  logic busy;
  int   n_cmp;
  int   n_err;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MEM_ARB_RR_EN
  localparam logic FIRST_D = 1'b0;
`else
  localparam logic FIRST_D = 1'b1;
`endif

  localparam logic [31:0]  IC_A  = 32'h0000_5000;
  localparam logic [31:0]  DC_A  = 32'h0000_4000;
  localparam logic [127:0] LINE1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One granted transfer with contention setup already applied; winner drops req in RESP.
  task automatic serve(input logic exp_d, input logic [127:0] rd, input string tag);
    tick();
    check({tag, " mem_req"}, bus.mem_req, 1);
    check({tag, " mem_addr"}, bus.mem_addr, exp_d ? DC_A : IC_A);
    check({tag, " mem_we"}, bus.mem_we, 0);
    tick();
    check({tag, " mem_req held"}, bus.mem_req, 1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rd;
    tick();
    bus.mem_ack = 1'b0;
    check({tag, " ic_ack"}, bus.ic_ack, !exp_d);
    check({tag, " dc_ack"}, bus.dc_ack, exp_d);
    check({tag, " rdata"}, exp_d ? bus.dc_rdata : bus.ic_rdata, rd);
    check({tag, " mem_req drop"}, bus.mem_req, 0);
    if (exp_d) bus.dc_req = 1'b0;
    else       bus.ic_req = 1'b0;
    tick();
    check({tag, " ack clear"}, {bus.ic_ack, bus.dc_ack}, 0);
    check({tag, " no grant in RESP"}, {bus.mem_req, busy}, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst          = 1'b0;
    bus.ic_req   = 1'b0;
    bus.ic_addr  = '0;
    bus.dc_req   = 1'b0;
    bus.dc_we    = 1'b0;
    bus.dc_addr  = '0;
    bus.dc_wdata = '0;
    bus.mem_ack  = 1'b0;
    bus.mem_rdata = '0;

    // Reset state
    tick();
    tick();
    check("rst mem_req", bus.mem_req, 0);
    check("rst mem_we", bus.mem_we, 0);
    check("rst mem_addr", bus.mem_addr, 0);
    check("rst mem_wdata", bus.mem_wdata, 0);
    check("rst acks", {bus.ic_ack, bus.dc_ack}, 0);
    check("rst rdata", bus.ic_rdata | bus.dc_rdata, 0);
    check("rst busy", busy, 0);
    rst = 1'b1;

    // Stray mem_ack in IDLE
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = LINE1;
    tick();
    bus.mem_ack = 1'b0;
    check("stray acks", {bus.ic_ack, bus.dc_ack}, 0);
    check("stray busy", busy, 0);
    tick();
    check("stray rdata", bus.ic_rdata, 0);

    // Single I refill, mem_ack four cycles after the request
    bus.ic_req  = 1'b1;
    bus.ic_addr = 32'h0000_1040;
    tick();
    check("i mem_req", bus.mem_req, 1);
    check("i mem_addr", bus.mem_addr, 32'h1040);
    check("i mem_we", bus.mem_we, 0);
    check("i busy", busy, 1);
    tick();
    tick();
    check("i no early ack", bus.ic_ack, 0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = LINE1;
    tick();
    bus.mem_ack = 1'b0;
    bus.ic_req  = 1'b0;
    check("i ic_ack", bus.ic_ack, 1);
    check("i ic_rdata", bus.ic_rdata, LINE1);
    check("i mem_req low", bus.mem_req, 0);
    tick();
    check("i ack one cycle", bus.ic_ack, 0);
    check("i idle", busy, 0);

    // D writeback with inputs disturbed mid-transfer
    bus.dc_req   = 1'b1;
    bus.dc_we    = 1'b1;
    bus.dc_addr  = 32'h0000_2000;
    bus.dc_wdata = {16{8'hA5}};
    tick();
    check("wb mem_we", bus.mem_we, 1);
    check("wb mem_addr", bus.mem_addr, 32'h2000);
    check("wb mem_wdata", bus.mem_wdata, {16{8'hA5}});
    bus.dc_addr  = 32'h0000_3000;
    bus.dc_wdata = '0;
    tick();
    check("wb addr latched", bus.mem_addr, 32'h2000);
    check("wb wdata latched", bus.mem_wdata, {16{8'hA5}});
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 128'h1111;
    tick();
    bus.mem_ack = 1'b0;
    bus.dc_req  = 1'b0;
    check("wb dc_ack", bus.dc_ack, 1);
    check("wb dc_rdata kept", bus.dc_rdata, 0);
    check("wb mem_we low", bus.mem_we, 0);
    tick();
    check("wb ack clear", bus.dc_ack, 0);
    tick();
    check("wb single pulse", bus.dc_ack, 0);

    // Reset in the middle of a D transfer, then a late mem_ack
    bus.dc_we   = 1'b0;
    bus.dc_addr = DC_A;
    bus.dc_req  = 1'b1;
    tick();
    check("rmid busy", busy, 1);
    rst = 1'b0;
    tick();
    tick();
    check("rmid mem_req", bus.mem_req, 0);
    check("rmid dc_ack", bus.dc_ack, 0);
    check("rmid busy", busy, 0);
    rst         = 1'b1;
    bus.dc_req  = 1'b0;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("late ack", {bus.ic_ack, bus.dc_ack, busy}, 0);

    // Contention: both raised together; loser served next IDLE; then a fresh pair
    bus.ic_addr = IC_A;
    bus.dc_addr = DC_A;
    bus.ic_req  = 1'b1;
    bus.dc_req  = 1'b1;
    serve(FIRST_D, 128'hA0A0, "arb1");
    serve(!FIRST_D, 128'hB1B1, "arb2");
    bus.ic_req = 1'b1;
    bus.dc_req = 1'b1;
    serve(FIRST_D, 128'hC2C2, "arb3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
